parity_frame_rx: RTL and testbench
==================================

# parity_frame_rx

Serial frame receiver that sits directly upstream of the 9-bit parity generator/checker. It samples a bit-enabled serial line carrying start / DATA_W data / parity / stop frames and assembles the data plus received parity bit into a (DATA_W+1)-bit word. It then presents that word on a valid/ready handshake with a registered parity-error flag and a saturating error counter. Downstream logic consumes `out_word` directly as the parity checker's input vector.

## Interface
Parameters:
- `DATA_W`, 8, data bits per frame; `out_word` is DATA_W+1 bits.
- `ODD_PARITY`, 1, 1 = a valid frame has an odd number of ones across data plus parity bit; 0 = even.
- `CNT_W`, 8, width of `err_count`.

Ports:
- `clk`  in  1  sole clock; all logic rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `bit_en`  in  1  one-cycle strobe per serial bit time; `sdi` sampled only when high.
- `sdi`  in  1  serial data, idle high, LSB first.
- `out_word`  out  DATA_W+1  `{parity_bit, data[DATA_W-1:0]}`.
- `out_valid`  out  1  `out_word` and `par_err` hold a frame.
- `out_ready`  in  1  consumer accepts when `out_valid && out_ready`.
- `par_err`  out  1  parity mismatch for the held word.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: completed frame dropped because the output was still occupied.
- `err_count`  out  CNT_W  saturating count of accepted frames with `par_err`=1.

## Operation
- FSM states: IDLE, DATA, PARITY, STOP. All transitions occur only on cycles with `bit_en`=1.
- IDLE: `sdi`=0 moves to DATA and clears the bit counter. `sdi`=1 stays in IDLE.
- DATA: shift `sdi` into data, LSB first. After DATA_W samples, move to PARITY.
- PARITY: capture `sdi` as the parity bit, then move to STOP.
- STOP, `sdi`=1: frame complete; attempt load, then return to IDLE.
- STOP, `sdi`=0: pulse `frame_err`, discard the frame, return to IDLE. No load and no counter change.
- Load rule:
  - If `out_valid`=0, or a transfer (`out_valid && out_ready`) happens in the same cycle, load `out_word` and `par_err`, and set `out_valid`=1.
  - Otherwise, pulse `overrun` and keep the old word and flag unchanged.
- `par_err` = `(^out_word) != ODD_PARITY`, computed from the word being loaded.
- `err_count` increments by 1 on each successful load with `par_err`=1. It saturates at 2^CNT_W-1 and never wraps.
- Transfer with no simultaneous load: `out_valid` clears next cycle. `out_word` and `par_err` keep their last values.
- `out_ready` has no effect while `out_valid`=0.

## Timing
- Reset: state IDLE, bit counter 0, `out_word` 0, `out_valid` 0, `par_err` 0, `frame_err` 0, `overrun` 0, `err_count` 0.
- Reset mid-frame aborts the frame with no outputs produced. Reset overrides all simultaneous events.
- Latency: `out_valid` rises on the clock edge after the cycle carrying the stop-bit `bit_en`. `frame_err` and `overrun` pulse on that same edge for exactly one cycle.
- A frame spans DATA_W+3 `bit_en` strobes. Back-to-back frames are legal: a start bit may immediately follow the stop bit.
- `bit_en` high on consecutive cycles is legal. Each high cycle is one bit.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Good frame, defaults: send start, data 0xA5 (bits 1,0,1,0,0,1,0,1), parity 1, stop 1 -> `out_word`=9'h1A5, `out_valid`=1 one cycle after the stop strobe, `par_err`=0, `err_count`=0.
- Bad parity: same frame with parity 0 -> `out_word`=9'h0A5, `par_err`=1, `err_count`=1. Hold `out_ready`=1 -> `out_valid` clears the next cycle.
- Framing: frame 0x3C, parity 1, stop sampled 0 -> `frame_err` high for one cycle, `out_valid` stays 0, `err_count` unchanged. The next good frame is received normally.
- Overrun and simultaneous transfer:
  - Hold `out_ready`=0 and send two good frames -> the second stop pulses `overrun`, and `out_word` keeps the first value.
  - Repeat with `out_ready`=1 exactly in the second stop's completion cycle -> no `overrun`, second word loaded, `out_valid` stays 1.
- Saturation: with CNT_W=2, send 5 bad-parity frames, each consumed -> `err_count` reads 1,2,3,3,3.
- Reset mid-frame: assert `rst` for one cycle after 4 data bits -> all outputs zero, no `out_valid`. A following full frame 0x01 with parity 0 yields `out_word`=9'h001 and `par_err`=0.

Source files
------------

// File: rtl/parity_frame_rx.sv
// Serial frame receiver: start / DATA_W data (LSB first) / parity / stop.
// Assembles {parity, data} into out_word and presents it on a valid/ready
// handshake with a registered parity-error flag and saturating error count.
module parity_frame_rx #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ODD_PARITY = 1,
  parameter int unsigned CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              sdi,
  output logic [DATA_W:0]   out_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              par_err,
  output logic              frame_err,
  output logic              overrun,
  output logic [CNT_W-1:0]  err_count
);

  localparam int unsigned CntBits = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  state_e              state_q, state_d;
  logic [CntBits-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                par_bit_q, par_bit_d;
  logic [DATA_W:0]     out_word_q, out_word_d;
  logic                out_valid_q, out_valid_d;
  logic                par_err_q, par_err_d;
  logic                frame_err_q, frame_err_d;
  logic                overrun_q, overrun_d;
  logic [CNT_W-1:0]    err_count_q, err_count_d;

  logic [DATA_W:0]     word_new;
  logic                new_par_err;
  logic                xfer;
  logic                load;

  // Next-state: framing FSM, output-slot load/overrun decision, error counter.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    data_d      = data_q;
    par_bit_d   = par_bit_q;
    out_word_d  = out_word_q;
    out_valid_d = out_valid_q;
    par_err_d   = par_err_q;
    err_count_d = err_count_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    load        = 1'b0;

    word_new    = {par_bit_q, data_q};
    new_par_err = (^word_new) != ODD_PARITY[0];
    xfer        = out_valid_q && out_ready;

    if (xfer) out_valid_d = 1'b0;

    if (bit_en) begin
      unique case (state_q)
        StIdle: begin
          if (!sdi) begin
            state_d   = StData;
            bit_cnt_d = '0;
          end
        end
        StData: begin
          data_d    = {sdi, data_q[DATA_W-1:1]};
          bit_cnt_d = bit_cnt_q + CntBits'(1);
          if (bit_cnt_q == CntBits'(DATA_W - 1)) state_d = StParity;
        end
        StParity: begin
          par_bit_d = sdi;
          state_d   = StStop;
        end
        StStop: begin
          state_d = StIdle;
          if (sdi) begin
            // A same-cycle transfer frees the slot, so the new word may load.
            if (!out_valid_q || xfer) load = 1'b1;
            else                      overrun_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (load) begin
      out_word_d  = word_new;
      par_err_d   = new_par_err;
      out_valid_d = 1'b1;
      if (new_par_err && (err_count_q != '1)) err_count_d = err_count_q + CNT_W'(1);
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      data_q      <= '0;
      par_bit_q   <= 1'b0;
      out_word_q  <= '0;
      out_valid_q <= 1'b0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      data_q      <= data_d;
      par_bit_q   <= par_bit_d;
      out_word_q  <= out_word_d;
      out_valid_q <= out_valid_d;
      par_err_q   <= par_err_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_word  = out_word_q;
  assign out_valid = out_valid_q;
  assign par_err   = par_err_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_parity_frame_rx.sv
// Directed bench for parity_frame_rx: default instance plus a CNT_W=2
// instance sharing the same stimulus for the saturation check.
module tb_parity_frame_rx;

  logic       clk;
  logic       rst;
  logic       bit_en;
  logic       sdi;
  logic       out_ready;

  logic [8:0] out_word;
  logic       out_valid;
  logic       par_err;
  logic       frame_err;
  logic       overrun;
  logic [7:0] err_count;

  logic [8:0] s_out_word;
  logic       s_out_valid;
  logic       s_par_err;
  logic       s_frame_err;
  logic       s_overrun;
  logic [1:0] s_err_count;

  int nvec;
  int nerr;

  parity_frame_rx dut (
    .clk       (clk),
    .rst       (rst),
    .bit_en    (bit_en),
    .sdi       (sdi),
    .out_word  (out_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .par_err   (par_err),
    .frame_err (frame_err),
    .overrun   (overrun),
    .err_count (err_count)
  );

  parity_frame_rx #(
    .DATA_W     (8),
    .ODD_PARITY (1),
    .CNT_W      (2)
  ) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .bit_en    (bit_en),
    .sdi       (sdi),
    .out_word  (s_out_word),
    .out_valid (s_out_valid),
    .out_ready (out_ready),
    .par_err   (s_par_err),
    .frame_err (s_frame_err),
    .overrun   (s_overrun),
    .err_count (s_err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bit time: strobe for one cycle, then return to sample point after the edge.
  task automatic send_bit(input logic b);
    bit_en = 1'b1;
    sdi    = b;
    tick();
    bit_en = 1'b0;
    sdi    = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                            input logic ready_on_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
    send_bit(par);
    out_ready = ready_on_stop;
    send_bit(stop);
    out_ready = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [1:0] sat_exp [5];
    nvec      = 0;
    nerr      = 0;
    rst       = 1'b1;
    bit_en    = 1'b0;
    sdi       = 1'b1;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check("rst_word", out_word, 9'h000);
    check("rst_valid", out_valid, 1'b0);
    check("rst_par_err", par_err, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_err_count", err_count, 8'd0);

    // Good frame 0xA5, parity 1 (five ones -> odd).
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    check("good_word", out_word, 9'h1A5);
    check("good_valid", out_valid, 1'b1);
    check("good_par_err", par_err, 1'b0);
    check("good_err_count", err_count, 8'd0);
    check("good_frame_err", frame_err, 1'b0);
    check("good_overrun", overrun, 1'b0);
    consume();
    check("good_valid_clr", out_valid, 1'b0);
    check("good_word_kept", out_word, 9'h1A5);

    // Bad parity: four ones total -> even.
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    check("bad_word", out_word, 9'h0A5);
    check("bad_par_err", par_err, 1'b1);
    check("bad_err_count", err_count, 8'd1);
    check("bad_valid", out_valid, 1'b1);
    consume();
    check("bad_valid_clr", out_valid, 1'b0);

    // Framing error on stop bit.
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    check("ferr_pulse", frame_err, 1'b1);
    check("ferr_valid", out_valid, 1'b0);
    check("ferr_err_count", err_count, 8'd1);
    tick();
    check("ferr_pulse_end", frame_err, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
    check("after_ferr_word", out_word, 9'h13C);
    check("after_ferr_valid", out_valid, 1'b1);
    check("after_ferr_par_err", par_err, 1'b0);
    consume();

    // Overrun: slot occupied and not drained.
    send_frame(8'h11, 1'b1, 1'b1, 1'b0);
    check("ovr_first_word", out_word, 9'h111);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0);
    check("ovr_pulse", overrun, 1'b1);
    check("ovr_word_kept", out_word, 9'h111);
    check("ovr_par_err_kept", par_err, 1'b0);
    check("ovr_err_count", err_count, 8'd1);
    check("ovr_valid", out_valid, 1'b1);
    tick();
    check("ovr_pulse_end", overrun, 1'b0);
    // Same-cycle transfer frees the slot for the new word.
    send_frame(8'h44, 1'b0, 1'b1, 1'b1);
    check("xfer_overrun", overrun, 1'b0);
    check("xfer_word", out_word, 9'h044);
    check("xfer_valid", out_valid, 1'b1);
    check("xfer_par_err", par_err, 1'b1);
    check("xfer_err_count", err_count, 8'd2);
    consume();

    // Saturation on the CNT_W=2 instance.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 5; i++) begin
      send_frame(8'h00, 1'b0, 1'b1, 1'b0);
      check($sformatf("sat_count_%0d", i), s_err_count, sat_exp[i]);
      consume();
    end
    check("sat_wide_count", err_count, 8'd5);

    // Reset mid-frame with an occupied output slot.
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_word", out_word, 9'h000);
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_par_err", par_err, 1'b0);
    check("mid_rst_err_count", err_count, 8'd0);
    check("mid_rst_frame_err", frame_err, 1'b0);
    check("mid_rst_overrun", overrun, 1'b0);
    send_frame(8'h01, 1'b0, 1'b1, 1'b0);
    check("post_rst_word", out_word, 9'h001);
    check("post_rst_valid", out_valid, 1'b1);
    check("post_rst_par_err", par_err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
